// File: rtl/rv32i_pkg.sv
`default_nettype none
// ============================================================================
// rv32i_pkg
// Shared integer-datapath widths, writeback request type and hazard helper.
// Rev 1.0
// ============================================================================
package rv32i_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } wb_req_t;

  // A source conflicts if it is pending in the scoreboard or being written right now.
  function automatic logic reg_hazard(
    input logic [REG_ADDR_W-1:0] rs,
    input logic [NUM_REGS-1:0]   busy,
    input logic                  wb_we,
    input logic [REG_ADDR_W-1:0] wb_addr
  );
    return (rs != '0) && (busy[rs] || (wb_we && (wb_addr == rs)));
  endfunction

endpackage
`default_nettype wire

// File: rtl/wb_fifo.sv
`default_nettype none
// ============================================================================
// wb_fifo
// Synchronous FIFO of load writeback requests with registered full/empty flags.
// Rev 1.0
// ============================================================================
module wb_fifo
  import rv32i_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    i_push,
  input  logic    i_pop,
  input  wb_req_t i_data,
  output logic    o_full,
  output logic    o_empty,
  output wb_req_t o_head
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] c_one   = CNT_W'(1);
  localparam logic [CNT_W-1:0] c_depth = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] c_step  = PTR_W'(1);

  wb_req_t          r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             r_full;
  logic             r_empty;

  logic             w_push;
  logic             w_pop;
  logic [CNT_W-1:0] w_count_next;

  assign w_push = i_push && !r_full;
  assign w_pop  = i_pop && !r_empty;

  always_comb begin
    w_count_next = r_count;
    if (w_push && !w_pop) begin
      w_count_next = r_count + c_one;
    end else if (!w_push && w_pop) begin
      w_count_next = r_count - c_one;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + c_step;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + c_step;
      r_count <= w_count_next;
      r_full  <= (w_count_next == c_depth);
      r_empty <= (w_count_next == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

  assign o_full  = r_full;
  assign o_empty = r_empty;
  assign o_head  = r_mem[r_rd_ptr];

endmodule
`default_nettype wire

// File: rtl/wb_scoreboard.sv
`default_nettype none
// ============================================================================
// wb_scoreboard
// Merges ALU and load writebacks onto the register-file port, tracks busy
// registers, and raises decode hazard stall and load-starvation drain request.
// Rev 1.0
// ============================================================================
module wb_scoreboard
  import rv32i_pkg::*;
#(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  issue_valid,
  input  logic [REG_ADDR_W-1:0] issue_rd,
  input  logic [REG_ADDR_W-1:0] issue_rs1,
  input  logic [REG_ADDR_W-1:0] issue_rs2,
  output logic                  hazard_stall,
  input  logic                  alu_valid,
  input  logic [REG_ADDR_W-1:0] alu_rd,
  input  logic [XLEN-1:0]       alu_data,
  input  logic                  ld_valid,
  output logic                  ld_ready,
  input  logic [REG_ADDR_W-1:0] ld_rd,
  input  logic [XLEN-1:0]       ld_data,
  output logic                  wb_we,
  output logic [REG_ADDR_W-1:0] wb_addr,
  output logic [XLEN-1:0]       wb_data,
  output logic                  drain_req
);

  localparam int SC_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [SC_W-1:0] c_starve_max = SC_W'(STARVE_LIMIT);
  localparam logic [SC_W-1:0] c_starve_thr = SC_W'(STARVE_LIMIT - 1);
  localparam logic [SC_W-1:0] c_starve_one = SC_W'(1);

  logic                  r_wb_we;
  logic [REG_ADDR_W-1:0] r_wb_addr;
  logic [XLEN-1:0]       r_wb_data;
  logic                  r_drain;
  logic [NUM_REGS-1:0]   r_busy;
  logic [SC_W-1:0]       r_starve;

  logic                  w_alu_req;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_fifo_full;
  logic                  w_fifo_empty;
  wb_req_t               w_head;
  wb_req_t               w_ld_req;
  logic                  w_wb_load;
  logic [REG_ADDR_W-1:0] w_wb_rd;
  logic [XLEN-1:0]       w_wb_dat;
  logic                  w_starve_inc;
  logic [NUM_REGS-1:0]   w_busy_next;

  assign w_alu_req    = alu_valid && (alu_rd != '0);
  assign w_push       = ld_valid && !w_fifo_full && (ld_rd != '0);
  assign w_pop        = !w_alu_req && !w_fifo_empty;
  assign w_wb_load    = w_alu_req || w_pop;
  assign w_wb_rd      = w_alu_req ? alu_rd : w_head.rd;
  assign w_wb_dat     = w_alu_req ? alu_data : w_head.data;
  assign w_starve_inc = w_alu_req && !w_fifo_empty;
  assign w_ld_req     = '{rd: ld_rd, data: ld_data};

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (w_ld_req),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty),
    .o_head  (w_head)
  );

  // Clear first so a same-edge issue to the retiring register keeps it busy.
  always_comb begin
    w_busy_next = r_busy;
    if (w_wb_load) w_busy_next[w_wb_rd] = 1'b0;
    if (issue_valid && (issue_rd != '0)) w_busy_next[issue_rd] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wb_we   <= 1'b0;
      r_wb_addr <= '0;
      r_wb_data <= '0;
      r_busy    <= '0;
      r_starve  <= '0;
      r_drain   <= 1'b0;
    end else begin
      r_wb_we <= w_wb_load;
      if (w_wb_load) begin
        r_wb_addr <= w_wb_rd;
        r_wb_data <= w_wb_dat;
      end
      r_busy <= w_busy_next;
      if (w_pop || w_fifo_empty) begin
        r_starve <= '0;
      end else if (w_starve_inc && (r_starve != c_starve_max)) begin
        r_starve <= r_starve + c_starve_one;
      end
      r_drain <= (r_starve >= c_starve_thr) && w_starve_inc;
    end
  end

  // The register file has no write-through, so the in-flight write also stalls.
  assign hazard_stall = reg_hazard(issue_rs1, r_busy, r_wb_we, r_wb_addr)
                      | reg_hazard(issue_rs2, r_busy, r_wb_we, r_wb_addr)
                      | reg_hazard(issue_rd,  r_busy, r_wb_we, r_wb_addr);

  assign ld_ready  = !w_fifo_full;
  assign wb_we     = r_wb_we;
  assign wb_addr   = r_wb_addr;
  assign wb_data   = r_wb_data;
  assign drain_req = r_drain;

endmodule
`default_nettype wire

// File: tb/tb_wb_scoreboard.sv
`default_nettype none
// ============================================================================
// tb_wb_scoreboard
// Directed and random stimulus against a queue-based reference model.
// Rev 1.0
// ============================================================================
module tb_wb_scoreboard;
  import rv32i_pkg::*;

  localparam int DEPTH        = 4;
  localparam int STARVE_LIMIT = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        issue_valid;
  logic [4:0]  issue_rd, issue_rs1, issue_rs2;
  logic        hazard_stall;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        ld_valid;
  logic        ld_ready;
  logic [4:0]  ld_rd;
  logic [31:0] ld_data;
  logic        wb_we;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        drain_req;

  always #5 clk = ~clk;

  wb_scoreboard #(.DEPTH(DEPTH), .STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clk          (clk),
    .rst          (rst),
    .issue_valid  (issue_valid),
    .issue_rd     (issue_rd),
    .issue_rs1    (issue_rs1),
    .issue_rs2    (issue_rs2),
    .hazard_stall (hazard_stall),
    .alu_valid    (alu_valid),
    .alu_rd       (alu_rd),
    .alu_data     (alu_data),
    .ld_valid     (ld_valid),
    .ld_ready     (ld_ready),
    .ld_rd        (ld_rd),
    .ld_data      (ld_data),
    .wb_we        (wb_we),
    .wb_addr      (wb_addr),
    .wb_data      (wb_data),
    .drain_req    (drain_req)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state
  bit          m_busy [32];
  wb_req_t     m_q [$];
  bit          m_we;
  logic [4:0]  m_addr;
  logic [31:0] m_data;
  int          m_cnt;
  bit          m_drain;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    foreach (m_busy[i]) m_busy[i] = 1'b0;
    m_q.delete();
    m_we    = 1'b0;
    m_addr  = '0;
    m_data  = '0;
    m_cnt   = 0;
    m_drain = 1'b0;
  endfunction

  function automatic bit m_hz(input logic [4:0] rs);
    return (rs != 0) && (m_busy[rs] || (m_we && m_addr == rs));
  endfunction

  task automatic model_edge();
    bit alu, nonempty, accept, popped, starved;
    wb_req_t h, e;
    alu      = alu_valid && (alu_rd != 0);
    nonempty = (m_q.size() > 0);
    accept   = ld_valid && (m_q.size() < DEPTH);
    popped   = !alu && nonempty;
    starved  = alu && nonempty;
    m_drain  = (m_cnt >= STARVE_LIMIT - 1) && starved;
    if (popped || !nonempty) m_cnt = 0;
    else if (starved && m_cnt < STARVE_LIMIT) m_cnt = m_cnt + 1;
    if (alu) begin
      m_we = 1'b1; m_addr = alu_rd; m_data = alu_data; m_busy[alu_rd] = 1'b0;
    end else if (popped) begin
      h = m_q.pop_front();
      m_we = 1'b1; m_addr = h.rd; m_data = h.data; m_busy[h.rd] = 1'b0;
    end else begin
      m_we = 1'b0;
    end
    if (accept && ld_rd != 0) begin
      e.rd = ld_rd; e.data = ld_data;
      m_q.push_back(e);
    end
    if (issue_valid && issue_rd != 0) m_busy[issue_rd] = 1'b1;
  endtask

  // One clock: check the combinational stall, clock, then check registered outputs.
  task automatic cyc();
    #1;
    chk("hazard_stall", hazard_stall, m_hz(issue_rs1) | m_hz(issue_rs2) | m_hz(issue_rd));
    @(posedge clk);
    model_edge();
    #1;
    chk("wb_we", wb_we, m_we);
    chk("wb_addr", wb_addr, m_addr);
    chk("wb_data", wb_data, m_data);
    chk("ld_ready", ld_ready, (m_q.size() < DEPTH));
    chk("drain_req", drain_req, m_drain);
  endtask

  task automatic idle_in();
    issue_valid = 0; issue_rd = 0; issue_rs1 = 0; issue_rs2 = 0;
    alu_valid = 0; alu_rd = 0; alu_data = 0;
    ld_valid = 0; ld_rd = 0; ld_data = 0;
  endtask

  initial begin
    rst = 1'b1;
    idle_in();
    model_reset();
    #2;
    chk("rst_wb_we", wb_we, 0);
    chk("rst_ld_ready", ld_ready, 1);
    chk("rst_hazard", hazard_stall, 0);
    chk("rst_drain", drain_req, 0);
    #10 rst = 1'b0;
    cyc(); cyc();

    // ALU path
    issue_valid = 1; issue_rd = 5; issue_rs1 = 5;
    cyc();
    issue_valid = 0; issue_rd = 0;
    alu_valid = 1; alu_rd = 5; alu_data = 32'hDEADBEEF;
    cyc();
    chk("alu_we", wb_we, 1);
    chk("alu_addr", wb_addr, 5);
    chk("alu_data", wb_data, 32'hDEADBEEF);
    alu_valid = 0;
    chk("alu_stall_wb", hazard_stall, 1);
    cyc(); cyc();
    chk("alu_stall_after", hazard_stall, 0);

    // ALU / load collision
    issue_valid = 1; issue_rd = 3; cyc();
    issue_rd = 4; cyc();
    issue_valid = 0; issue_rd = 0; issue_rs1 = 3; issue_rs2 = 4;
    alu_valid = 1; alu_rd = 3; alu_data = 32'h11;
    ld_valid = 1; ld_rd = 4; ld_data = 32'h22;
    cyc();
    chk("col_first_addr", wb_addr, 3);
    alu_valid = 0; ld_valid = 0;
    cyc();
    chk("col_second_addr", wb_addr, 4);
    chk("col_second_data", wb_data, 32'h22);
    cyc(); cyc();

    // FIFO full and load starvation
    idle_in();
    alu_valid = 1; alu_rd = 7;
    for (int i = 0; i < 4; i++) begin
      ld_valid = 1; ld_rd = 5'(8 + i); ld_data = 32'h100 + i;
      alu_data = $urandom;
      cyc();
    end
    chk("full_ld_ready", ld_ready, 0);
    ld_rd = 12; ld_data = 32'hBAD;
    for (int i = 0; i < 5; i++) begin
      alu_data = $urandom;
      cyc();
    end
    chk("starve_drain", drain_req, 1);
    alu_valid = 0; ld_valid = 0;
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("retire_order", wb_addr, 5'(8 + i));
      chk("drain_fall", drain_req, 0);
    end
    cyc(); cyc();

    // x0 handling
    idle_in();
    alu_valid = 1; alu_rd = 0; alu_data = 32'h55;
    ld_valid = 1; ld_rd = 6; ld_data = 32'h66;
    issue_valid = 1;
    #1 chk("x0_stall", hazard_stall, 0);
    cyc();
    idle_in();
    cyc();
    chk("x0_load_addr", wb_addr, 6);
    chk("x0_load_we", wb_we, 1);
    ld_valid = 1; ld_rd = 0; ld_data = 32'h77;
    cyc();
    ld_valid = 0;
    cyc();
    chk("x0_load_drop", wb_we, 0);

    // Reset mid-operation
    issue_valid = 1; issue_rd = 9; cyc();
    idle_in();
    alu_valid = 1; alu_rd = 7; alu_data = 32'h1;
    ld_valid = 1; ld_rd = 13; ld_data = 32'hD13; cyc();
    ld_rd = 14; ld_data = 32'hD14; cyc();
    idle_in();
    issue_rs1 = 9;
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_we", wb_we, 0);
    chk("mid_rst_ready", ld_ready, 1);
    chk("mid_rst_drain", drain_req, 0);
    chk("mid_rst_busy9", hazard_stall, 0);
    model_reset();
    @(posedge clk);
    #3 rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("post_rst_no_we", wb_we, 0);
    end

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      issue_valid = 1'($urandom);
      issue_rd    = 5'($urandom_range(0, 7));
      issue_rs1   = 5'($urandom_range(0, 7));
      issue_rs2   = 5'($urandom_range(0, 7));
      alu_valid   = ($urandom_range(0, 2) == 0);
      alu_rd      = 5'($urandom_range(0, 7));
      alu_data    = $urandom;
      ld_valid    = 1'($urandom);
      ld_rd       = 5'($urandom_range(0, 7));
      ld_data     = $urandom;
      cyc();
    end
    idle_in();
    repeat (6) cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
